// File: rtl/approx_mul_pipe.sv
// Pipelined unsigned multiplier with per-transaction exact / lower-part-OR approximate mode.
// Three valid/ready stages: operand capture, carry-save reduction, final add.
module approx_mul_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned K     = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    input  logic               in_approx,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_z,
    output logic               out_approx,
    input  logic               cnt_clr,
    output logic [31:0]        approx_cnt
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = 32;
    localparam logic [PW-1:0] LOW_MASK = PW'((64'(1) << K) - 64'(1));

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_x;
    logic [WIDTH-1:0] r_s1_y;
    logic             r_s1_approx;

    logic             r_s2_valid;
    logic [PW-1:0]    r_s2_sum;
    logic [PW-1:0]    r_s2_carry;
    logic [PW-1:0]    r_s2_low;
    logic             r_s2_approx;

    logic             r_s3_valid;
    logic [PW-1:0]    r_out_z;
    logic             r_out_approx;

    logic [CW-1:0]    r_cnt;

    logic             w_s3_free;
    logic             w_s2_free;
    logic             w_s1_free;
    logic             w_accept;
    logic             w_cnt_inc;

    logic [PW-1:0]    w_col_mask;
    logic [PW-1:0]    w_row;
    logic [PW-1:0]    w_sum;
    logic [PW-1:0]    w_carry;
    logic [PW-1:0]    w_sum_nxt;
    logic [PW-1:0]    w_low;

    // A stage is free when empty or when its content leaves this cycle.
    assign w_s3_free = !r_s3_valid || out_ready;
    assign w_s2_free = !r_s2_valid || w_s3_free;
    assign w_s1_free = !r_s1_valid || w_s2_free;

    assign in_ready  = !rst && w_s1_free;
    assign w_accept  = in_valid && in_ready;
    assign w_cnt_inc = w_accept && in_approx;

    // Carry-save reduction of the partial-product rows; low columns are OR-folded instead.
    always_comb begin
        w_col_mask = r_s1_approx ? ~LOW_MASK : '1;
        w_row      = '0;
        w_sum      = '0;
        w_carry    = '0;
        w_sum_nxt  = '0;
        w_low      = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_row     = r_s1_x[i] ? (PW'(r_s1_y) << i) : '0;
            w_low     = w_low | (w_row & ~w_col_mask);
            w_row     = w_row & w_col_mask;
            w_sum_nxt = w_sum ^ w_carry ^ w_row;
            w_carry   = ((w_sum & w_carry) | (w_sum & w_row) | (w_carry & w_row)) << 1;
            w_sum     = w_sum_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_x       <= '0;
            r_s1_y       <= '0;
            r_s1_approx  <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_s2_sum     <= '0;
            r_s2_carry   <= '0;
            r_s2_low     <= '0;
            r_s2_approx  <= 1'b0;
            r_s3_valid   <= 1'b0;
            r_out_z      <= '0;
            r_out_approx <= 1'b0;
        end else begin
            if (w_s1_free) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_x      <= in_x;
                    r_s1_y      <= in_y;
                    r_s1_approx <= in_approx;
                end
            end
            if (w_s2_free) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_sum    <= w_sum;
                    r_s2_carry  <= w_carry;
                    r_s2_low    <= w_low;
                    r_s2_approx <= r_s1_approx;
                end
            end
            if (w_s3_free) begin
                r_s3_valid <= r_s2_valid;
                if (r_s2_valid) begin
                    // Low OR bits occupy columns the carry-save vectors never reach.
                    r_out_z      <= r_s2_sum + r_s2_carry + r_s2_low;
                    r_out_approx <= r_s2_approx;
                end
            end
        end
    end

    // Approximate-operation counter; a clear coinciding with a counted accept leaves 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= w_cnt_inc ? CW'(1) : CW'(0);
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign out_valid  = r_s3_valid;
    assign out_z      = r_out_z;
    assign out_approx = r_out_approx;
    assign approx_cnt = r_cnt;

endmodule
